// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared bus command encodings used by all memory requesters.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Arbiter state type and starvation-limit default.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2,
    ARB_RESP   = 2'd3
  } arb_state_t;

  localparam logic [2:0] STARVE_LIMIT_DEFAULT = 3'd4;

endpackage
`default_nettype wire

// File: rtl/mem_arb_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_starve_ctr
// Description : Counts data grants taken while a fetch waits; flags the limit.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter logic [2:0] STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic data_grant,
  input  logic fetch_grant,
  input  logic fetch_pending,
  output logic at_limit
);

  logic [2:0] r_cnt;

  // The limit forces a fetch grant, so the count never runs past it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 3'd0;
    end else if (fetch_grant) begin
      r_cnt <= 3'd0;
    end else if (data_grant && fetch_pending) begin
      r_cnt <= r_cnt + 3'd1;
    end
  end

  assign at_limit = (r_cnt == STARVE_LIMIT);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Fetch/data arbiter onto one shared memory port, data priority.
//               Define ARB_STARVE_GUARD_EN to bound fetch starvation.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import bus_pkg::*;
  import mem_arb_pkg::*;
#(
  parameter logic [2:0] STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  if_cmd,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic [1:0]  dm_cmd,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_done,
  output logic [1:0]  mem_cmd,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_if,
  output logic        stall_mem
);

  localparam logic [1:0] c_IDLE   = ARB_IDLE;
  localparam logic [1:0] c_BUSY_I = ARB_BUSY_I;
  localparam logic [1:0] c_BUSY_D = ARB_BUSY_D;
  localparam logic [1:0] c_RESP   = ARB_RESP;

  if (STARVE_LIMIT == 3'd0) begin : g_limit_check
    $error("mem_arbiter: STARVE_LIMIT must be in 1..7");
  end

  logic [1:0]  r_state;
  logic        r_fetch;
  logic [1:0]  r_cmd;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_if_rdata;
  logic [31:0] r_dm_rdata;

  logic w_if_req;
  logic w_dm_req;
  logic w_force_if;
  logic w_idle;
  logic w_busy;
  logic w_grant_d;
  logic w_grant_i;

  assign w_if_req = (if_cmd != BUS_NONE);
  assign w_dm_req = (dm_cmd != BUS_NONE);
  assign w_idle   = (r_state == c_IDLE);
  assign w_busy   = (r_state == c_BUSY_I) || (r_state == c_BUSY_D);

`ifdef ARB_STARVE_GUARD_EN
  logic w_at_limit;

  mem_arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk           (clk),
    .rst           (rst),
    .data_grant    (w_grant_d),
    .fetch_grant   (w_grant_i),
    .fetch_pending (w_if_req),
    .at_limit      (w_at_limit)
  );

  assign w_force_if = w_at_limit & w_if_req;
`else
  assign w_force_if = 1'b0;
`endif

  assign w_grant_d = w_idle && w_dm_req && !w_force_if;
  assign w_grant_i = w_idle && w_if_req && (!w_dm_req || w_force_if);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_IDLE;
      r_fetch    <= 1'b0;
      r_cmd      <= BUS_NONE;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_if_rdata <= 32'd0;
      r_dm_rdata <= 32'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_grant_d) begin
            r_state <= c_BUSY_D;
            r_fetch <= 1'b0;
            r_cmd   <= dm_cmd;
            r_addr  <= dm_addr;
            r_wdata <= dm_wdata;
          end else if (w_grant_i) begin
            // Fetches are always reads regardless of the requested code.
            r_state <= c_BUSY_I;
            r_fetch <= 1'b1;
            r_cmd   <= BUS_LOAD;
            r_addr  <= if_addr;
            r_wdata <= 32'd0;
          end
        end
        c_BUSY_I: begin
          if (mem_ack) begin
            r_if_rdata <= mem_rdata;
            r_state    <= c_RESP;
          end
        end
        c_BUSY_D: begin
          if (mem_ack) begin
            if (r_cmd != BUS_STORE) begin
              r_dm_rdata <= mem_rdata;
            end
            r_state <= c_RESP;
          end
        end
        c_RESP:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign mem_cmd   = w_busy ? r_cmd   : BUS_NONE;
  assign mem_addr  = w_busy ? r_addr  : 32'd0;
  assign mem_wdata = w_busy ? r_wdata : 32'd0;

  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign if_done   = (r_state == c_RESP) &&  r_fetch;
  assign dm_done   = (r_state == c_RESP) && !r_fetch;

  assign stall_if  = w_if_req & ~if_done;
  assign stall_mem = w_dm_req & ~dm_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed and randomized checks of mem_arbiter against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
  import bus_pkg::*;

  localparam logic [2:0] LIMIT = 3'd2;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  if_cmd = BUS_NONE;
  logic [31:0] if_addr = 32'd0;
  logic [31:0] if_rdata;
  logic        if_done;
  logic [1:0]  dm_cmd = BUS_NONE;
  logic [31:0] dm_addr = 32'd0;
  logic [31:0] dm_wdata = 32'd0;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic [1:0]  mem_cmd;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;
  logic        stall_if;
  logic        stall_mem;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_cmd(if_cmd), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_cmd(dm_cmd), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model: one outstanding transaction, described by its owner
  // (1 fetch, 2 data) and phase (0 none, 1 on the memory port, 2 reporting).
  int          m_phase, m_who, m_starve;
  logic [1:0]  m_cmd;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
  bit          if_act, dm_act;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_cmd = BUS_NONE; if_addr = 32'd0;
    dm_cmd = BUS_NONE; dm_addr = 32'd0; dm_wdata = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    if_act = 1'b0; dm_act = 1'b0;
    m_phase = 0; m_who = 0; m_starve = 0;
    m_cmd = BUS_NONE; m_addr = 32'd0; m_wdata = 32'd0;
    m_if_rdata = 32'd0; m_dm_rdata = 32'd0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  // Advance the model across the coming rising edge using the driven inputs.
  task automatic model_step();
    bit f, d, force_if;
    case (m_phase)
      0: begin
        f = (if_cmd != BUS_NONE);
        d = (dm_cmd != BUS_NONE);
        force_if = GUARD && f && (m_starve >= int'(LIMIT));
        if (d && !force_if) begin
          m_who = 2; m_phase = 1;
          m_cmd = dm_cmd; m_addr = dm_addr; m_wdata = dm_wdata;
          if (f) m_starve++;
        end else if (f) begin
          m_who = 1; m_phase = 1;
          m_cmd = BUS_LOAD; m_addr = if_addr; m_wdata = 32'd0;
          m_starve = 0;
        end
      end
      1: begin
        if (mem_ack) begin
          if (m_who == 1) m_if_rdata = mem_rdata;
          else if (m_cmd != BUS_STORE) m_dm_rdata = mem_rdata;
          m_phase = 2;
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic run_random(input int cycles, input bit sat, output int fetch_dones);
    bit e_busy, e_ifd, e_dmd;
    fetch_dones = 0;
    for (int c = 0; c < cycles; c++) begin
      step();
      e_busy = (m_phase == 1);
      e_ifd  = (m_phase == 2) && (m_who == 1);
      e_dmd  = (m_phase == 2) && (m_who == 2);
      check_eq("rnd_mem_cmd",   mem_cmd,   e_busy ? m_cmd   : BUS_NONE);
      check_eq("rnd_mem_addr",  mem_addr,  e_busy ? m_addr  : 32'd0);
      check_eq("rnd_mem_wdata", mem_wdata, e_busy ? m_wdata : 32'd0);
      check_eq("rnd_if_done",   if_done,   e_ifd);
      check_eq("rnd_dm_done",   dm_done,   e_dmd);
      check_eq("rnd_if_rdata",  if_rdata,  m_if_rdata);
      check_eq("rnd_dm_rdata",  dm_rdata,  m_dm_rdata);
      check_eq("rnd_stall_if",  stall_if,  (if_cmd != BUS_NONE) && !e_ifd);
      check_eq("rnd_stall_mem", stall_mem, (dm_cmd != BUS_NONE) && !e_dmd);
      if (if_done) fetch_dones++;

      if (e_ifd) begin if_act = 1'b0; if_cmd = BUS_NONE; end
      if (e_dmd) begin dm_act = 1'b0; dm_cmd = BUS_NONE; end
      if (!if_act && (sat || $urandom_range(0, 3) == 0)) begin
        if_act = 1'b1; if_cmd = 2'($urandom_range(1, 3)); if_addr = $urandom;
      end
      if (!dm_act && (sat || $urandom_range(0, 2) == 0)) begin
        dm_act = 1'b1; dm_cmd = 2'($urandom_range(1, 2));
        dm_addr = $urandom; dm_wdata = $urandom;
      end
      // Granted requester wobbles its operands; the latched copy must win.
      if (m_phase == 1 && m_who == 1 && $urandom_range(0, 1) == 1) if_addr = $urandom;
      if (m_phase == 1 && m_who == 2 && $urandom_range(0, 1) == 1) begin
        dm_addr = $urandom; dm_wdata = $urandom;
      end
      mem_ack   = (m_phase == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
      model_step();
    end
  endtask

  int fd;

  initial begin
    do_reset();
    check_eq("rst_mem_cmd", mem_cmd, BUS_NONE);
    check_eq("rst_if_done", if_done, 1'b0);
    check_eq("rst_dm_done", dm_done, 1'b0);
    check_eq("rst_if_rdata", if_rdata, 32'd0);
    check_eq("rst_dm_rdata", dm_rdata, 32'd0);

    // Fetch only, ack at cycle 3.
    if_cmd = BUS_LOAD; if_addr = 32'h100;
    step();
    check_eq("fo_c1_cmd", mem_cmd, BUS_LOAD);
    check_eq("fo_c1_addr", mem_addr, 32'h100);
    check_eq("fo_c1_wdata", mem_wdata, 32'd0);
    step();
    check_eq("fo_c2_cmd", mem_cmd, BUS_LOAD);
    check_eq("fo_c2_done", if_done, 1'b0);
    step();
    check_eq("fo_c3_cmd", mem_cmd, BUS_LOAD);
    mem_ack = 1'b1; mem_rdata = 32'h00A00093;
    step();
    mem_ack = 1'b0;
    check_eq("fo_c4_if_done", if_done, 1'b1);
    check_eq("fo_c4_dm_done", dm_done, 1'b0);
    check_eq("fo_c4_rdata", if_rdata, 32'h00A00093);
    check_eq("fo_c4_cmd", mem_cmd, BUS_NONE);
    check_eq("fo_c4_stall", stall_if, 1'b0);
    if_cmd = BUS_NONE;
    step();
    check_eq("fo_c5_done", if_done, 1'b0);
    check_eq("fo_c5_rdata", if_rdata, 32'h00A00093);

    // Spurious ack while idle.
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    step();
    mem_ack = 1'b0;
    check_eq("sp_if_done", if_done, 1'b0);
    check_eq("sp_dm_done", dm_done, 1'b0);
    check_eq("sp_cmd", mem_cmd, BUS_NONE);
    check_eq("sp_if_rdata", if_rdata, 32'h00A00093);
    check_eq("sp_dm_rdata", dm_rdata, 32'd0);
    step();
    check_eq("sp_c2_if_done", if_done, 1'b0);
    if_cmd = BUS_LOAD; if_addr = 32'h200;
    step();
    check_eq("sp_grant_cmd", mem_cmd, BUS_LOAD);
    check_eq("sp_grant_addr", mem_addr, 32'h200);

    // Simultaneous store and fetch, ack latency 1.
    do_reset();
    dm_cmd = BUS_STORE; dm_addr = 32'h2000; dm_wdata = 32'hDEADBEEF;
    if_cmd = BUS_LOAD;  if_addr = 32'h104;
    step();
    check_eq("sim_c1_cmd", mem_cmd, BUS_STORE);
    check_eq("sim_c1_addr", mem_addr, 32'h2000);
    check_eq("sim_c1_wdata", mem_wdata, 32'hDEADBEEF);
    check_eq("sim_c1_stall_if", stall_if, 1'b1);
    check_eq("sim_c1_stall_mem", stall_mem, 1'b1);
    mem_ack = 1'b1; mem_rdata = 32'h55555555;
    step();
    mem_ack = 1'b0;
    check_eq("sim_c2_dm_done", dm_done, 1'b1);
    check_eq("sim_c2_if_done", if_done, 1'b0);
    check_eq("sim_c2_dm_rdata", dm_rdata, 32'd0);
    check_eq("sim_c2_stall_if", stall_if, 1'b1);
    check_eq("sim_c2_stall_mem", stall_mem, 1'b0);
    dm_cmd = BUS_NONE;
    step();
    check_eq("sim_c3_cmd", mem_cmd, BUS_NONE);
    check_eq("sim_c3_stall_if", stall_if, 1'b1);
    step();
    check_eq("sim_c4_cmd", mem_cmd, BUS_LOAD);
    check_eq("sim_c4_addr", mem_addr, 32'h104);
    check_eq("sim_c4_wdata", mem_wdata, 32'd0);
    check_eq("sim_c4_stall_if", stall_if, 1'b1);
    mem_ack = 1'b1; mem_rdata = 32'h13579BDF;
    step();
    mem_ack = 1'b0;
    check_eq("sim_c5_if_done", if_done, 1'b1);
    check_eq("sim_c5_if_rdata", if_rdata, 32'h13579BDF);
    check_eq("sim_c5_stall_if", stall_if, 1'b0);
    if_cmd = BUS_NONE;

    // Saturated data traffic with a fetch always waiting.
    do_reset();
    run_random(120, 1'b1, fd);
    if (GUARD) check_eq("starve_fetch_granted", (fd > 0), 1'b1);
    else       check_eq("starve_fetch_blocked", fd, 32'd0);

    // General randomized traffic.
    do_reset();
    run_random(3000, 1'b0, fd);

    // Reset in the middle of a data transaction.
    do_reset();
    dm_cmd = BUS_LOAD; dm_addr = 32'h30;
    step();
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    step();
    mem_ack = 1'b0;
    check_eq("rm_pre_dm_rdata", dm_rdata, 32'h12345678);
    dm_cmd = BUS_NONE;
    step();
    dm_cmd = BUS_LOAD; dm_addr = 32'h40;
    step();
    check_eq("rm_busy_cmd", mem_cmd, BUS_LOAD);
    rst = 1'b1;
    #1;
    check_eq("rm_async_cmd", mem_cmd, BUS_NONE);
    check_eq("rm_async_addr", mem_addr, 32'd0);
    check_eq("rm_async_dm_rdata", dm_rdata, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_ack = 1'b0;
    check_eq("rm_ack_dm_done", dm_done, 1'b0);
    rst = 1'b0; dm_cmd = BUS_NONE;
    step();
    check_eq("rm_post_cmd", mem_cmd, BUS_NONE);
    check_eq("rm_post_dm_done", dm_done, 1'b0);
    check_eq("rm_post_dm_rdata", dm_rdata, 32'd0);
    dm_cmd = BUS_LOAD; dm_addr = 32'h80;
    step();
    check_eq("rm_idle_grant_cmd", mem_cmd, BUS_LOAD);
    check_eq("rm_idle_grant_addr", mem_addr, 32'h80);
    dm_cmd = BUS_NONE;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
